// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Byte-stream command responder sitting behind a UART. Decodes write
//   (0xAA, addr, data) and read (0xBB, addr) frames against an internal
//   register file and returns read data through the UART transmitter's
//   valid/busy handshake.
//
//   Build option: define CMD_ACK_EN to have every completed write answered
//   with a 0xCC acknowledge byte sent the same way as read data. Without it
//   a write is silent.
//
// Ports
//   CLK            system clock, rising edge
//   RST            synchronous active-low reset
//   RX_P_DATA      received byte
//   RX_DATA_VALID  one-cycle strobe qualifying RX_P_DATA
//   TX_Busy        transmitter busy
//   TX_P_DATA      byte to transmit (held until the frame returns to IDLE)
//   TX_DATA_VALID  one-cycle transmit request
//   FRAME_ERR      one-cycle pulse on an unknown opcode
module uart_cmd_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_DATA_VALID,
  input  logic                  TX_Busy,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  output logic                  FRAME_ERR
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [DATA_WIDTH-1:0] OP_WR    = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD    = DATA_WIDTH'(8'hBB);
`ifdef CMD_ACK_EN
  localparam logic [DATA_WIDTH-1:0] ACK_BYTE = DATA_WIDTH'(8'hCC);
`endif

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    SEND,
    WAIT_ACK
  } state_t;

  state_t                              state;
  logic [ADDR_WIDTH-1:0]               wr_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    regs;

  // Upper address bits of the operand byte are ignored.
  logic [ADDR_WIDTH-1:0] rx_addr;
  assign rx_addr = RX_P_DATA[ADDR_WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= IDLE;
      wr_addr       <= '0;
      regs          <= '0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      FRAME_ERR     <= 1'b0;
    end else begin
      // Both strobes default low so neither can stretch past one cycle.
      TX_DATA_VALID <= 1'b0;
      FRAME_ERR     <= 1'b0;

      case (state)
        IDLE: begin
          if (RX_DATA_VALID) begin
            if (RX_P_DATA == OP_WR)      state <= WR_ADDR;
            else if (RX_P_DATA == OP_RD) state <= RD_ADDR;
            else                         FRAME_ERR <= 1'b1;
          end
        end

        // Mid-frame every byte is an operand, even if it looks like an opcode.
        WR_ADDR: begin
          if (RX_DATA_VALID) begin
            wr_addr <= rx_addr;
            state   <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (RX_DATA_VALID) begin
            regs[wr_addr] <= RX_P_DATA;
`ifdef CMD_ACK_EN
            TX_P_DATA     <= ACK_BYTE;
            state         <= SEND;
`else
            state         <= IDLE;
`endif
          end
        end

        RD_ADDR: begin
          if (RX_DATA_VALID) begin
            TX_P_DATA <= regs[rx_addr];
            state     <= SEND;
          end
        end

        // Request held off for as long as the transmitter stays busy.
        SEND: begin
          if (!TX_Busy) begin
            TX_DATA_VALID <= 1'b1;
            state         <= WAIT_ACK;
          end
        end

        // Busy rising is the transmitter accepting the byte; received bytes
        // in SEND/WAIT_ACK are dropped silently.
        WAIT_ACK: begin
          if (TX_Busy) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
